// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the register bridge.
// Holds the response codes, the write/read FSM state types and a small
// helper that turns the native port error flag into an AXI response code.
package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RESP
  } rd_state_t;

  // The bridge only ever reports OKAY or SLVERR; DECERR belongs to the crossbar.
  function automatic logic [1:0] respCode(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite interface bundle with manager and subordinate views.
// Ports: aclk (clock), areset_n (active-low reset, carried for completeness).
// Channels: AW, W, B, AR, R with the usual valid/ready handshakes.
interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32
) (
  input logic aclk,
  input logic areset_n
);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport subordinate (
    input  aclk, areset_n,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport manager (
    input  aclk, areset_n,
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

endinterface

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite subordinate that turns each accepted transaction into one
// single-word access on a native register port.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   axi             - AXI4-Lite subordinate port (AW, W, B, AR, R)
//   reg_req/reg_we  - one-cycle access strobe and write flag
//   reg_addr        - word index (byte offset bits dropped)
//   reg_wdata/wstrb - write data and byte enables
//   reg_rdata/err   - read data and error, valid the cycle after reg_req
// Independent write and read FSMs share the native port; writes win ties.
import axi4_lite_pkg::*;

module axi4_lite_reg_bridge #(
  parameter int WIDTH            = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int LOCAL_ADDR_WIDTH = 4
) (
  input  logic                                            clk,
  input  logic                                            rst,
  axi4_lite.subordinate                                   axi,
  output logic                                            reg_req,
  output logic                                            reg_we,
  output logic [LOCAL_ADDR_WIDTH-$clog2(WIDTH/8)-1:0]     reg_addr,
  output logic [WIDTH-1:0]                                reg_wdata,
  output logic [WIDTH/8-1:0]                              reg_wstrb,
  input  logic [WIDTH-1:0]                                reg_rdata,
  input  logic                                            reg_err
);

  localparam int BYTE_BITS = $clog2(WIDTH/8);
  localparam int IDX_W     = LOCAL_ADDR_WIDTH - BYTE_BITS;

  wr_state_t          r_wState;
  logic               r_awHeld;
  logic               r_wHeld;
  logic [IDX_W-1:0]   r_awIdx;
  logic [WIDTH-1:0]   r_wData;
  logic [WIDTH/8-1:0] r_wStrb;
  logic               r_bvalid;
  logic [1:0]         r_bresp;

  rd_state_t          r_rState;
  logic [IDX_W-1:0]   r_arIdx;
  logic               r_rvalid;
  logic [1:0]         r_rresp;
  logic [WIDTH-1:0]   r_rdata;

  logic w_awReady;
  logic w_wReady;
  logic w_arReady;
  logic w_awFire;
  logic w_wFire;
  logic w_arFire;
  logic w_writeGrant;
  logic w_readGrant;
  logic w_unused;

  // Readies come straight from state: each channel accepts only while idle
  // and not already holding a beat, so it stays low until its response completes.
  assign w_awReady = (r_wState == W_IDLE) && !r_awHeld;
  assign w_wReady  = (r_wState == W_IDLE) && !r_wHeld;
  assign w_arReady = (r_rState == R_IDLE);

  assign w_awFire = axi.awvalid && w_awReady;
  assign w_wFire  = axi.wvalid  && w_wReady;
  assign w_arFire = axi.arvalid && w_arReady;

  // Single priority line: a pending write always takes the native port.
  assign w_writeGrant = (r_wState == W_REQ);
  assign w_readGrant  = (r_rState == R_REQ) && !w_writeGrant;

  assign reg_req   = w_writeGrant || w_readGrant;
  assign reg_we    = w_writeGrant;
  assign reg_addr  = w_writeGrant ? r_awIdx : r_arIdx;
  assign reg_wdata = r_wData;
  assign reg_wstrb = r_wStrb;

  assign axi.awready = w_awReady;
  assign axi.wready  = w_wReady;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = w_arReady;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;

  // Protection bits, the clock/reset copies in the bundle and the address bits
  // outside the local word index carry no meaning for this bridge.
  assign w_unused = ^{axi.aclk, axi.areset_n, axi.awprot, axi.arprot,
                      axi.awaddr, axi.araddr};

  // Write FSM: AW and W are captured independently; the cycle the second one
  // lands we move straight to W_REQ so the access issues on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wState <= W_IDLE;
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_awIdx  <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (w_awFire) begin
            r_awHeld <= 1'b1;
            r_awIdx  <= axi.awaddr[LOCAL_ADDR_WIDTH-1:BYTE_BITS];
          end
          if (w_wFire) begin
            r_wHeld <= 1'b1;
            r_wData <= axi.wdata;
            r_wStrb <= axi.wstrb;
          end
          if ((r_awHeld || w_awFire) && (r_wHeld || w_wFire)) begin
            r_wState <= W_REQ;
          end
        end
        W_REQ: begin
          if (w_writeGrant) begin
            r_wState <= W_WAIT;
          end
        end
        W_WAIT: begin
          r_bresp  <= respCode(reg_err);
          r_bvalid <= 1'b1;
          r_wState <= W_RESP;
        end
        W_RESP: begin
          if (axi.bready) begin
            r_bvalid <= 1'b0;
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_wState <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch the word index on AR, wait for the port, then register
  // data and error the cycle after the access and hold them until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rState <= R_IDLE;
      r_arIdx  <= '0;
      r_rvalid <= 1'b0;
      r_rresp  <= OKAY;
      r_rdata  <= '0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (w_arFire) begin
            r_arIdx  <= axi.araddr[LOCAL_ADDR_WIDTH-1:BYTE_BITS];
            r_rState <= R_REQ;
          end
        end
        R_REQ: begin
          if (w_readGrant) begin
            r_rState <= R_WAIT;
          end
        end
        R_WAIT: begin
          r_rdata  <= reg_rdata;
          r_rresp  <= respCode(reg_err);
          r_rvalid <= 1'b1;
          r_rState <= R_RESP;
        end
        R_RESP: begin
          if (axi.rready) begin
            r_rvalid <= 1'b0;
            r_rState <= R_IDLE;
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Directed bench for axi4_lite_reg_bridge: drives AXI4-Lite beats and the
// native read-data/error inputs, and compares outputs against hand-computed values.
module tb_axi4_lite_reg_bridge;

  logic        clk;
  logic        rst;
  logic        rstN;
  logic        regReq;
  logic        regWe;
  logic [1:0]  regAddr;
  logic [31:0] regWdata;
  logic [3:0]  regWstrb;
  logic [31:0] regRdata;
  logic        regErr;

  int checks;
  int errors;
  int writeReqCount;
  int reqSnapshot;

  assign rstN = ~rst;

  axi4_lite #(.ADDR_WIDTH(32), .WIDTH(32)) axi (
    .aclk     (clk),
    .areset_n (rstN)
  );

  axi4_lite_reg_bridge #(
    .WIDTH            (32),
    .ADDR_WIDTH       (32),
    .LOCAL_ADDR_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .reg_req   (regReq),
    .reg_we    (regWe),
    .reg_addr  (regAddr),
    .reg_wdata (regWdata),
    .reg_wstrb (regWstrb),
    .reg_rdata (regRdata),
    .reg_err   (regErr)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count native write strobes so duplicate accesses are visible.
  always @(posedge clk) begin
    if (regReq && regWe) begin
      writeReqCount <= writeReqCount + 1;
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every manager-side AXI input for the coming edge.
  task automatic applyStimulus(
    input logic        awv,
    input logic [31:0] awa,
    input logic        wv,
    input logic [31:0] wd,
    input logic [3:0]  ws,
    input logic        br,
    input logic        arv,
    input logic [31:0] ara,
    input logic        rr
  );
    axi.awvalid = awv;
    axi.awaddr  = awa;
    axi.wvalid  = wv;
    axi.wdata   = wd;
    axi.wstrb   = ws;
    axi.bready  = br;
    axi.arvalid = arv;
    axi.araddr  = ara;
    axi.rready  = rr;
  endtask

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    writeReqCount = 0;
    rst           = 1'b1;
    regRdata      = 32'h0;
    regErr        = 1'b0;
    axi.awprot    = 3'b000;
    axi.arprot    = 3'b000;
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_awready", axi.awready, 1'b1);
    checkOutput("rst_wready",  axi.wready,  1'b1);
    checkOutput("rst_arready", axi.arready, 1'b1);
    checkOutput("rst_bvalid",  axi.bvalid,  1'b0);
    checkOutput("rst_rvalid",  axi.rvalid,  1'b0);
    checkOutput("rst_bresp",   axi.bresp,   2'b00);
    checkOutput("rst_rresp",   axi.rresp,   2'b00);
    checkOutput("rst_rdata",   axi.rdata,   32'h0);
    checkOutput("rst_reg_req", regReq,      1'b0);

    $display("[TB] write AW+W same cycle, addr 0x8");
    applyStimulus(1, 32'h8, 1, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    checkOutput("w1_req",     regReq,      1'b1);
    checkOutput("w1_we",      regWe,       1'b1);
    checkOutput("w1_addr",    regAddr,     2'd2);
    checkOutput("w1_wdata",   regWdata,    32'hDEADBEEF);
    checkOutput("w1_wstrb",   regWstrb,    4'hF);
    checkOutput("w1_awready", axi.awready, 1'b0);
    checkOutput("w1_wready",  axi.wready,  1'b0);
    tick();
    checkOutput("w1_req_off", regReq,      1'b0);
    checkOutput("w1_b_early", axi.bvalid,  1'b0);
    tick();
    checkOutput("w1_bvalid",  axi.bvalid,  1'b1);
    checkOutput("w1_bresp",   axi.bresp,   2'b00);
    tick();
    checkOutput("w1_bhold",   axi.bvalid,  1'b1);
    checkOutput("w1_awr_hold", axi.awready, 1'b0);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checkOutput("w1_bdone",   axi.bvalid,  1'b0);
    checkOutput("w1_awready_back", axi.awready, 1'b1);
    checkOutput("w1_wready_back",  axi.wready,  1'b1);

    $display("[TB] W three cycles ahead of AW, addr 0x4");
    reqSnapshot = writeReqCount;
    applyStimulus(0, 32'h0, 1, 32'hCAFEF00D, 4'h3, 0, 0, 32'h0, 0);
    tick();
    axi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("w2_wready_held", axi.wready,  1'b0);
      checkOutput("w2_awready",     axi.awready, 1'b1);
      checkOutput("w2_no_req",      regReq,      1'b0);
      if (i < 2) tick();
    end
    applyStimulus(1, 32'h4, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    tick();
    axi.awvalid = 1'b0;
    checkOutput("w2_req",   regReq,   1'b1);
    checkOutput("w2_addr",  regAddr,  2'd1);
    checkOutput("w2_wdata", regWdata, 32'hCAFEF00D);
    checkOutput("w2_wstrb", regWstrb, 4'h3);
    tick();
    tick();
    checkOutput("w2_bvalid", axi.bvalid, 1'b1);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checkOutput("w2_single_access", writeReqCount - reqSnapshot, 1);

    $display("[TB] read addr 0xC with held rready");
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'hC, 0);
    checkOutput("r1_arready_idle", axi.arready, 1'b1);
    tick();
    axi.arvalid = 1'b0;
    regRdata = 32'h12345678;
    regErr   = 1'b0;
    checkOutput("r1_req",     regReq,      1'b1);
    checkOutput("r1_we",      regWe,       1'b0);
    checkOutput("r1_addr",    regAddr,     2'd3);
    checkOutput("r1_arready", axi.arready, 1'b0);
    tick();
    checkOutput("r1_r_early", axi.rvalid,  1'b0);
    tick();
    regRdata = 32'hFFFFFFFF;
    checkOutput("r1_rvalid", axi.rvalid, 1'b1);
    checkOutput("r1_rdata",  axi.rdata,  32'h12345678);
    checkOutput("r1_rresp",  axi.rresp,  2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("r1_rvalid_hold", axi.rvalid,  1'b1);
      checkOutput("r1_rdata_hold",  axi.rdata,   32'h12345678);
      checkOutput("r1_arready_low", axi.arready, 1'b0);
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checkOutput("r1_rdone",        axi.rvalid,  1'b0);
    checkOutput("r1_arready_back", axi.arready, 1'b1);

    $display("[TB] write and read contend for the native port");
    applyStimulus(1, 32'h0, 1, 32'h11112222, 4'hF, 0, 1, 32'h8, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    regErr = 1'b0;
    checkOutput("c_first_req",  regReq,   1'b1);
    checkOutput("c_first_we",   regWe,    1'b1);
    checkOutput("c_first_addr", regAddr,  2'd0);
    checkOutput("c_first_data", regWdata, 32'h11112222);
    tick();
    regRdata = 32'hA5A5A5A5;
    checkOutput("c_second_req",  regReq,  1'b1);
    checkOutput("c_second_we",   regWe,   1'b0);
    checkOutput("c_second_addr", regAddr, 2'd2);
    tick();
    checkOutput("c_bvalid",   axi.bvalid, 1'b1);
    checkOutput("c_bresp",    axi.bresp,  2'b00);
    checkOutput("c_r_early",  axi.rvalid, 1'b0);
    checkOutput("c_req_idle", regReq,     1'b0);
    tick();
    checkOutput("c_rvalid", axi.rvalid, 1'b1);
    checkOutput("c_rdata",  axi.rdata,  32'hA5A5A5A5);
    checkOutput("c_bhold",  axi.bvalid, 1'b1);
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    checkOutput("c_bdone", axi.bvalid, 1'b0);
    checkOutput("c_rdone", axi.rvalid, 1'b0);

    $display("[TB] error responses");
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'h4, 0);
    tick();
    axi.arvalid = 1'b0;
    regErr   = 1'b1;
    regRdata = 32'hBAD0BAD0;
    tick();
    tick();
    checkOutput("e_rvalid", axi.rvalid, 1'b1);
    checkOutput("e_rresp",  axi.rresp,  2'b10);
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    applyStimulus(1, 32'hC, 1, 32'h00000001, 4'h1, 0, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    checkOutput("e_w_addr", regAddr, 2'd3);
    tick();
    tick();
    checkOutput("e_bvalid", axi.bvalid, 1'b1);
    checkOutput("e_bresp",  axi.bresp,  2'b10);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    regErr = 1'b0;

    $display("[TB] reset during W_WAIT");
    applyStimulus(1, 32'h0, 1, 32'h55555555, 4'hF, 0, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("x_bvalid",  axi.bvalid,  1'b0);
    checkOutput("x_awready", axi.awready, 1'b1);
    checkOutput("x_wready",  axi.wready,  1'b1);
    checkOutput("x_arready", axi.arready, 1'b1);
    checkOutput("x_reg_req", regReq,      1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("x_no_b", axi.bvalid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
